// File: rtl/edge_frame_ctrl.sv
// Frame sequencer: streams one frame (plus flush lines) into the edge filter, thresholds its output into edge memory.
// Stream and writes lag reads/filter beats by one register; no backpressure, one beat per de cycle each way.
module edge_frame_ctrl #(
  parameter int WIDTH       = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int H_BLANK     = 16,
  parameter int VS_LEN      = 4,
  parameter int FLUSH_LINES = 2,
  parameter int SKIP_PIX    = 641,
  parameter int DRAIN_CYC   = 8,
  parameter int AW          = $clog2(H_RES*V_RES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] thresh,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             fb_rd_en,
  output logic [AW-1:0]    fb_rd_addr,
  input  logic [WIDTH-1:0] fb_rd_data,
  output logic             f_vsync,
  output logic             f_hsync,
  output logic             f_de,
  output logic [WIDTH-1:0] f_data,
  input  logic             f_o_de,
  input  logic [WIDTH-1:0] f_o_data,
  output logic             em_wr_en,
  output logic [AW-1:0]    em_wr_addr,
  output logic             em_wr_data
);

  localparam int TOTAL  = H_RES * V_RES;
  localparam int BEATS  = (V_RES + FLUSH_LINES) * H_RES;
  localparam int CMAX   = (BEATS > SKIP_PIX) ? BEATS : SKIP_PIX;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int PM1    = (H_RES > H_BLANK) ? H_RES : H_BLANK;
  localparam int PM2    = (VS_LEN > DRAIN_CYC) ? VS_LEN : DRAIN_CYC;
  localparam int PH_MAX = (PM1 > PM2) ? PM1 : PM2;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int LMAX   = (V_RES > FLUSH_LINES) ? V_RES : FLUSH_LINES;
  localparam int LW     = $clog2(LMAX + 1);

  localparam logic [PW-1:0] VS_END  = PW'(VS_LEN - 1);
  localparam logic [PW-1:0] H_END   = PW'(H_RES - 1);
  localparam logic [PW-1:0] HB_END  = PW'(H_BLANK - 1);
  localparam logic [PW-1:0] DR_END  = PW'(DRAIN_CYC - 1);
  localparam logic [PW-1:0] HS_LEN  = PW'(2);
  localparam logic [LW-1:0] L_END   = LW'(V_RES - 1);
  localparam logic [LW-1:0] FL_END  = LW'(FLUSH_LINES - 1);
  localparam logic [AW-1:0] RD_END  = AW'(TOTAL - 1);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [CW-1:0] SKIP_C  = CW'(SKIP_PIX);

  typedef enum logic [2:0] {S_IDLE, S_VS, S_LINE, S_HB, S_FLUSH, S_DRAIN, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ph, ph_nxt;
  logic [LW-1:0]    ln, ln_nxt;
  logic             fl_blank, fl_blank_nxt;
  logic [AW-1:0]    rd_addr, rd_addr_nxt;
  logic             accept;
  logic             vs_ph, hs_ph, de_ph, src_ph;
  logic             src_fb;
  logic [CW-1:0]    beat_cnt, wr_cnt;
  logic [WIDTH-1:0] thresh_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      ph       <= '0;
      ln       <= '0;
      fl_blank <= 1'b0;
      rd_addr  <= '0;
    end else begin
      state    <= state_nxt;
      ph       <= ph_nxt;
      ln       <= ln_nxt;
      fl_blank <= fl_blank_nxt;
      rd_addr  <= rd_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ph_nxt       = ph;
    ln_nxt       = ln;
    fl_blank_nxt = fl_blank;
    rd_addr_nxt  = rd_addr;
    accept       = 1'b0;
    busy         = (state != S_IDLE);
    done         = (state == S_FIN);
    err          = (state == S_FIN) && (wr_cnt != TOTAL_C);
    fb_rd_en     = (state == S_LINE);
    vs_ph        = (state == S_VS);
    src_ph       = (state == S_LINE);
    de_ph        = (state == S_LINE) || (state == S_FLUSH && !fl_blank);
    hs_ph        = ((state == S_HB) || (state == S_FLUSH && fl_blank)) && (ph < HS_LEN);
    case (state)
      S_IDLE: begin
        if (start) begin
          accept       = 1'b1;
          state_nxt    = S_VS;
          ph_nxt       = '0;
          ln_nxt       = '0;
          fl_blank_nxt = 1'b0;
          rd_addr_nxt  = '0;
        end
      end
      S_VS: begin
        if (ph == VS_END) begin
          state_nxt = S_LINE;
          ph_nxt    = '0;
        end else ph_nxt = ph + 1'b1;
      end
      S_LINE: begin
        // Address parks on the last pixel rather than wrapping past the frame.
        if (rd_addr != RD_END) rd_addr_nxt = rd_addr + 1'b1;
        if (ph == H_END) begin
          state_nxt = S_HB;
          ph_nxt    = '0;
        end else ph_nxt = ph + 1'b1;
      end
      S_HB: begin
        if (ph == HB_END) begin
          ph_nxt = '0;
          if (ln == L_END) begin
            ln_nxt    = '0;
            state_nxt = (FLUSH_LINES > 0) ? S_FLUSH : S_DRAIN;
          end else begin
            ln_nxt    = ln + 1'b1;
            state_nxt = S_LINE;
          end
        end else ph_nxt = ph + 1'b1;
      end
      S_FLUSH: begin
        if (!fl_blank) begin
          if (ph == H_END) begin
            fl_blank_nxt = 1'b1;
            ph_nxt       = '0;
          end else ph_nxt = ph + 1'b1;
        end else if (ph == HB_END) begin
          ph_nxt       = '0;
          fl_blank_nxt = 1'b0;
          if (ln == FL_END) state_nxt = S_DRAIN;
          else ln_nxt = ln + 1'b1;
        end else ph_nxt = ph + 1'b1;
      end
      S_DRAIN: begin
        if (ph == DR_END) begin
          state_nxt = S_FIN;
          ph_nxt    = '0;
        end else ph_nxt = ph + 1'b1;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign fb_rd_addr = rd_addr;

  // Sync/de ride one register behind the read so they line up with the RAM's 1-cycle data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_vsync <= 1'b0;
      f_hsync <= 1'b0;
      f_de    <= 1'b0;
      src_fb  <= 1'b0;
    end else begin
      f_vsync <= vs_ph;
      f_hsync <= hs_ph;
      f_de    <= de_ph;
      src_fb  <= src_ph;
    end
  end

  assign f_data = src_fb ? fb_rd_data : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt   <= '0;
      wr_cnt     <= '0;
      thresh_q   <= '0;
      em_wr_en   <= 1'b0;
      em_wr_addr <= '0;
      em_wr_data <= 1'b0;
    end else if (accept) begin
      beat_cnt <= '0;
      wr_cnt   <= '0;
      thresh_q <= thresh;
      em_wr_en <= 1'b0;
    end else begin
      em_wr_en <= 1'b0;
      if (f_o_de && busy) begin
        // beat_cnt only needs to reach SKIP_PIX, so it saturates there.
        if (beat_cnt < SKIP_C) begin
          beat_cnt <= beat_cnt + 1'b1;
        end else if (wr_cnt < TOTAL_C) begin
          em_wr_en   <= 1'b1;
          em_wr_addr <= wr_cnt[AW-1:0];
          em_wr_data <= (f_o_data >= thresh_q);
          wr_cnt     <= wr_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// Directed bench for edge_frame_ctrl: stream timing, capture/threshold, short output, ignored start, resets.
module tb_edge_frame_ctrl;

  localparam int WIDTH = 8;
  localparam int H_RES = 8;
  localparam int V_RES = 4;
  localparam int H_BLANK = 4;
  localparam int VS_LEN = 2;
  localparam int FLUSH_LINES = 2;
  localparam int SKIP_PIX = 9;
  localparam int DRAIN_CYC = 8;
  localparam int AW = 5;
  localparam int TOTAL = H_RES * V_RES;
  localparam int NPH = VS_LEN + (V_RES + FLUSH_LINES) * (H_RES + H_BLANK) + DRAIN_CYC + 1;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  logic [WIDTH-1:0] thresh = '0;
  logic busy, done, err, fb_rd_en, f_vsync, f_hsync, f_de, em_wr_en, em_wr_data;
  logic [AW-1:0] fb_rd_addr, em_wr_addr;
  logic [WIDTH-1:0] fb_rd_data = '0;
  logic [WIDTH-1:0] f_data;
  logic f_o_de = 1'b0;
  logic [WIDTH-1:0] f_o_data = '0;

  always #5 clk = ~clk;

  edge_frame_ctrl #(
    .WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES), .H_BLANK(H_BLANK), .VS_LEN(VS_LEN),
    .FLUSH_LINES(FLUSH_LINES), .SKIP_PIX(SKIP_PIX), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .thresh(thresh),
    .busy(busy), .done(done), .err(err),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .f_vsync(f_vsync), .f_hsync(f_hsync), .f_de(f_de), .f_data(f_data),
    .f_o_de(f_o_de), .f_o_data(f_o_data),
    .em_wr_en(em_wr_en), .em_wr_addr(em_wr_addr), .em_wr_data(em_wr_data)
  );

  // Frame buffer: data = address, one cycle latency.
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= WIDTH'(fb_rd_addr);

  // Filter: 4-cycle delay of the stream, optionally dropping beats after the 30th.
  logic [2:0] de_p = '0;
  logic [WIDTH-1:0] dat_p0 = '0, dat_p1 = '0, dat_p2 = '0;
  int o_cnt = 0;
  bit drop_mode = 1'b0;
  always @(posedge clk) begin
    de_p     <= {de_p[1:0], f_de};
    dat_p0   <= f_data;
    dat_p1   <= dat_p0;
    dat_p2   <= dat_p1;
    f_o_de   <= de_p[2] && !(drop_mode && o_cnt >= 30);
    f_o_data <= dat_p2;
    if (start && !busy) o_cnt <= 0;
    else if (de_p[2]) o_cnt <= o_cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle phase after the accepting edge; the stream shows phase n-1 at cycle n.
  bit ph_rd [NPH];
  bit ph_vs [NPH];
  bit ph_hs [NPH];
  bit ph_de [NPH];
  logic [WIDTH-1:0] ph_dat [NPH];

  task automatic set_ph(input int i, input bit rd, input bit vs, input bit hs, input bit de, input int dat);
    ph_rd[i] = rd; ph_vs[i] = vs; ph_hs[i] = hs; ph_de[i] = de; ph_dat[i] = WIDTH'(dat);
  endtask

  task automatic build_phases();
    int i = 0;
    for (int k = 0; k < NPH; k++) set_ph(k, 0, 0, 0, 0, 0);
    for (int v = 0; v < VS_LEN; v++) begin set_ph(i, 0, 1, 0, 0, 0); i++; end
    for (int l = 0; l < V_RES + FLUSH_LINES; l++) begin
      for (int c = 0; c < H_RES; c++) begin
        if (l < V_RES) set_ph(i, 1, 0, 0, 1, l * H_RES + c);
        else set_ph(i, 0, 0, 0, 1, 0);
        i++;
      end
      for (int b = 0; b < H_BLANK; b++) begin set_ph(i, 0, 0, (b < 2), 0, 0); i++; end
    end
  endtask

  function automatic bit exp_bit(input int k, input int thr);
    int b = SKIP_PIX + k;
    int v = (b < TOTAL) ? b : 0;
    return (v >= thr);
  endfunction

  function automatic logic [31:0] outv();
    return {5'b0, busy, done, err, fb_rd_en, fb_rd_addr, f_vsync, f_hsync, f_de, f_data,
            em_wr_en, em_wr_addr, em_wr_data};
  endfunction

  task automatic run_frame(input string name, input int thr, input bit drop, input bit poke,
                           input int exp_wr, input bit exp_err);
    int m_vs = 0, m_hs = 0, m_de = 0, m_dat = 0, m_rd = 0, m_addr = 0, m_busy = 0, m_done = 0;
    int m_post = 0, wcnt = 0, m_waddr = 0, m_wdat = 0;
    logic [AW-1:0] first_addr = '1;
    logic err_fin = 1'b0;
    bit em_img [TOTAL];
    bit e_vs, e_hs, e_de;
    logic [WIDTH-1:0] e_dat;
    for (int k = 0; k < TOTAL; k++) em_img[k] = 1'b0;
    drop_mode = drop;
    thresh = WIDTH'(thr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < NPH; n++) begin
      if (n == 0) begin e_vs = 0; e_hs = 0; e_de = 0; e_dat = '0; end
      else begin e_vs = ph_vs[n-1]; e_hs = ph_hs[n-1]; e_de = ph_de[n-1]; e_dat = ph_dat[n-1]; end
      if (f_vsync !== e_vs) m_vs++;
      if (f_hsync !== e_hs) m_hs++;
      if (f_de !== e_de) m_de++;
      if (e_de && f_data !== e_dat) m_dat++;
      if (fb_rd_en !== ph_rd[n]) m_rd++;
      if (ph_rd[n] && fb_rd_addr !== AW'(ph_dat[n])) m_addr++;
      if (busy !== 1'b1) m_busy++;
      if (done !== (n == NPH - 1)) m_done++;
      if (n == NPH - 1) err_fin = err;
      else if (err !== 1'b0) m_done++;
      if (em_wr_en) begin
        if (wcnt == 0) first_addr = em_wr_addr;
        if (em_wr_addr !== AW'(wcnt)) m_waddr++;
        if (em_wr_data !== exp_bit(wcnt, thr)) m_wdat++;
        if (wcnt < TOTAL) em_img[wcnt] = em_wr_data;
        wcnt++;
      end
      if (poke && n == 5) start = 1'b1;
      if (poke && n == 6) start = 1'b0;
      if (poke && n == 20) thresh = 8'd200;
      if (poke && n == NPH - 1) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0 || em_wr_en !== 1'b0) m_post++;
    if (poke) begin
      repeat (5) begin
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0 || em_wr_en !== 1'b0) m_post++;
      end
    end
    drop_mode = 1'b0;
    chk_eq({name, ".vsync"}, m_vs, 0);
    chk_eq({name, ".hsync"}, m_hs, 0);
    chk_eq({name, ".de"}, m_de, 0);
    chk_eq({name, ".data"}, m_dat, 0);
    chk_eq({name, ".rd_en"}, m_rd, 0);
    chk_eq({name, ".rd_addr"}, m_addr, 0);
    chk_eq({name, ".busy"}, m_busy, 0);
    chk_eq({name, ".done_timing"}, m_done, 0);
    chk_eq({name, ".idle_after"}, m_post, 0);
    chk_eq({name, ".wr_count"}, wcnt, exp_wr);
    chk_eq({name, ".first_wr_addr"}, first_addr, 0);
    chk_eq({name, ".wr_addr"}, m_waddr, 0);
    chk_eq({name, ".wr_data"}, m_wdat, 0);
    chk_eq({name, ".bit_val15"}, em_img[6], exp_bit(6, thr));
    chk_eq({name, ".bit_val16"}, em_img[7], exp_bit(7, thr));
    chk_eq({name, ".err"}, err_fin, exp_err);
  endtask

  initial begin
    int stray;
    build_phases();
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("reset.outputs", outv(), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk_eq("reset.idle_busy", busy, 0);

    run_frame("A", 16, 0, 0, 32, 0);
    run_frame("B2B", 16, 0, 0, 32, 0);
    repeat (10) @(negedge clk);
    run_frame("SHORT", 16, 1, 0, 21, 1);
    repeat (10) @(negedge clk);
    run_frame("POKE", 16, 0, 1, 32, 0);
    repeat (10) @(negedge clk);

    thresh = 8'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk_eq("midrst.pre_busy", busy, 1);
    chk_eq("midrst.pre_rd_en", fb_rd_en, 1);
    rstn = 1'b0;
    #1;
    chk_eq("midrst.outputs", outv(), 0);
    @(negedge clk);
    rstn = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) stray++;
    end
    chk_eq("midrst.no_done", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
